// File: rtl/rv32i_pkg.sv
// Shared RV32I constants: load/store funct3 sizes and LSU FSM states.
package rv32i_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsuState_t;

  // Unknown funct3 codes fall back to a word access.
  function automatic logic [1:0] f3Size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: f3Size = SZ_B;
      F3_H, F3_HU: f3Size = SZ_H;
      default:     f3Size = SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// LSU lane logic: byte enables, store replication, load extract/extend.
// Illegal-access detection only when LSU_MISALIGN_TRAP_EN is defined.
module lsu_align
  import rv32i_pkg::*;
(
  input  logic [2:0]  f3Req,
  input  logic [1:0]  addrLo,
  input  logic [31:0] wdataReq,
  input  logic [2:0]  f3Rsp,
  input  logic [1:0]  offRsp,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [1:0]  offMask,
  output logic [31:0] wdataRep,
  output logic [31:0] rdExt,
  output logic        illegal
);

  logic [1:0]  szReq;
  logic [31:0] shifted;

  assign szReq   = f3Size(f3Req);
  assign shifted = rdata >> {offRsp, 3'b000};

  always_comb begin
    be       = 4'b1111;
    offMask  = 2'b00;
    wdataRep = wdataReq;
    case (szReq)
      SZ_B: begin
        offMask  = addrLo;
        be       = 4'b0001 << addrLo;
        wdataRep = {4{wdataReq[7:0]}};
      end
      SZ_H: begin
        offMask  = {addrLo[1], 1'b0};
        be       = 4'b0011 << {addrLo[1], 1'b0};
        wdataRep = {2{wdataReq[15:0]}};
      end
      default: begin
        be = 4'b1111;
      end
    endcase
  end

  always_comb begin
    rdExt = rdata;
    case (f3Rsp)
      F3_B:    rdExt = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   rdExt = {24'b0, shifted[7:0]};
      F3_H:    rdExt = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   rdExt = {16'b0, shifted[15:0]};
      default: rdExt = rdata;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    illegal = 1'b1;
    case (f3Req)
      F3_B, F3_BU: illegal = 1'b0;
      F3_H, F3_HU: illegal = addrLo[0];
      F3_W:        illegal = |addrLo;
      default:     illegal = 1'b1;
    endcase
  end
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: rtl/mem_lsu.sv
// M-stage load/store unit: req/gnt/rvalid FSM and registered memory port.
// Optional LSU_MISALIGN_TRAP_EN turns misaligned accesses into traps.
module mem_lsu
  import rv32i_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        validM,
  input  logic        memreadM,
  input  logic        memwriteM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] addrM,
  input  logic [31:0] wdataM,
  input  logic        holdM,
  output logic        stallM,
  output logic [31:0] dm_rdM,
  output logic        misalignM,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_gnt,
  input  logic        dm_rvalid,
  input  logic [31:0] dm_rdata
);

  lsuState_t   state, stateNext;
  logic        access;
  logic [2:0]  f3Q;
  logic [1:0]  offQ;
  logic [3:0]  beReq;
  logic [1:0]  offReq;
  logic [31:0] wdataRep;
  logic [31:0] rdExt;
  logic        illegal;

  assign access = validM & (memreadM | memwriteM);

  lsu_align uAlign (
    .f3Req    (funct3M),
    .addrLo   (addrM[1:0]),
    .wdataReq (wdataM),
    .f3Rsp    (f3Q),
    .offRsp   (offQ),
    .rdata    (dm_rdata),
    .be       (beReq),
    .offMask  (offReq),
    .wdataRep (wdataRep),
    .rdExt    (rdExt),
    .illegal  (illegal)
  );

  always_comb begin
    stateNext = state;
    stallM    = 1'b0;
    unique case (state)
      IDLE: begin
        stallM = access;
        if (access) stateNext = illegal ? DONE : REQ;
      end
      REQ: begin
        stallM = 1'b1;
        if (dm_gnt) stateNext = dm_we ? DONE : WAIT;
      end
      WAIT: begin
        stallM = 1'b1;
        if (dm_rvalid) stateNext = DONE;
      end
      DONE: begin
        if (!holdM) stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      dm_req   <= 1'b0;
      dm_we    <= 1'b0;
      dm_addr  <= '0;
      dm_be    <= '0;
      dm_wdata <= '0;
      dm_rdM   <= '0;
      f3Q      <= '0;
      offQ     <= '0;
    end else begin
      state  <= stateNext;
      dm_req <= (stateNext == REQ);
      if (state == IDLE && access) begin
        dm_we    <= memwriteM;
        dm_addr  <= {addrM[31:2], 2'b00};
        dm_be    <= beReq;
        dm_wdata <= wdataRep;
        f3Q      <= funct3M;
        offQ     <= offReq;
      end
      if (state == REQ && dm_gnt && dm_we)
        dm_rdM <= '0;
      if (state == WAIT && dm_rvalid)
        dm_rdM <= rdExt;
      if (state == IDLE && access && illegal)
        dm_rdM <= '0;
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic misQ;

  // Set on the trap entry, held for as long as DONE is extended by holdM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misQ <= 1'b0;
    end else begin
      misQ <= (state == IDLE && access && illegal) |
              (misQ && stateNext == DONE);
    end
  end

  assign misalignM = misQ;
`else
  assign misalignM = 1'b0;
`endif

endmodule

// File: tb/tb_mem_lsu.sv
// Directed self-checking bench for mem_lsu.
// Covers stores, loads, holds, reset in WAIT and LSU_MISALIGN_TRAP_EN.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        validM, memreadM, memwriteM, holdM;
  logic [2:0]  funct3M;
  logic [31:0] addrM, wdataM;
  logic        stallM, misalignM;
  logic [31:0] dm_rdM;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_gnt, dm_rvalid;
  logic [31:0] dm_rdata;

  int checks = 0;
  int failures = 0;
  int stalls, reqs;
  bit done;

  always #5 clk = ~clk;

  mem_lsu dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .validM    (validM),
    .memreadM  (memreadM),
    .memwriteM (memwriteM),
    .funct3M   (funct3M),
    .addrM     (addrM),
    .wdataM    (wdataM),
    .holdM     (holdM),
    .stallM    (stallM),
    .dm_rdM    (dm_rdM),
    .misalignM (misalignM),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_be     (dm_be),
    .dm_wdata  (dm_wdata),
    .dm_gnt    (dm_gnt),
    .dm_rvalid (dm_rvalid),
    .dm_rdata  (dm_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleIn();
    validM    = 1'b0;
    memreadM  = 1'b0;
    memwriteM = 1'b0;
    dm_gnt    = 1'b0;
    dm_rvalid = 1'b0;
  endtask

  // Entered in IDLE; returns during the DONE cycle with inputs still driven.
  task automatic doAccess(input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rd, input int gntDelay,
                          input int rvDelay, output int nStall,
                          output int nReq, output bit fin);
    int reqCyc = 0;
    int wCyc = 0;
    bit granted = 0;
    nStall = 0;
    nReq = 0;
    fin = 0;
    validM    = 1'b1;
    memreadM  = ~we;
    memwriteM = we;
    funct3M   = f3;
    addrM     = addr;
    wdataM    = wd;
    dm_rdata  = rd;
    for (int cyc = 0; cyc < 60; cyc++) begin
      dm_gnt    = 1'b0;
      dm_rvalid = 1'b0;
      if (granted && !we) begin
        dm_rvalid = (wCyc == rvDelay);
        wCyc++;
      end
      if (dm_req && !granted) begin
        dm_gnt = (reqCyc == gntDelay);
        reqCyc++;
        nReq++;
      end
      #1;
      if (!stallM) begin
        fin = 1;
        break;
      end
      nStall++;
      if (dm_gnt) granted = 1;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    holdM    = 1'b0;
    funct3M  = 3'b000;
    addrM    = '0;
    wdataM   = '0;
    dm_rdata = '0;
    idleIn();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {31'b0, dm_req}, 32'd0);
    chk("rst_we", {31'b0, dm_we}, 32'd0);
    chk("rst_addr", dm_addr, 32'd0);
    chk("rst_be", {28'b0, dm_be}, 32'd0);
    chk("rst_wdata", dm_wdata, 32'd0);
    chk("rst_rdM", dm_rdM, 32'd0);
    chk("rst_mis", {31'b0, misalignM}, 32'd0);
    chk("rst_stall", {31'b0, stallM}, 32'd0);
    rst_n = 1'b1;
    tick();

    // SW 0x100, immediate grant
    doAccess(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0,
             stalls, reqs, done);
    chk("sw_done", {31'b0, done}, 32'd1);
    chk("sw_stall", stalls, 32'd2);
    chk("sw_reqs", reqs, 32'd1);
    chk("sw_addr", dm_addr, 32'h100);
    chk("sw_be", {28'b0, dm_be}, 32'hF);
    chk("sw_wdata", dm_wdata, 32'hDEADBEEF);
    chk("sw_we", {31'b0, dm_we}, 32'd1);
    chk("sw_rdM", dm_rdM, 32'd0);
    idleIn();
    tick();
    chk("sw_idle_req", {31'b0, dm_req}, 32'd0);
    chk("sw_idle_stall", {31'b0, stallM}, 32'd0);

    // LB 0x103
    doAccess(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_FFFF, 0, 0,
             stalls, reqs, done);
    chk("lb_done", {31'b0, done}, 32'd1);
    chk("lb_stall", stalls, 32'd3);
    chk("lb_rdM", dm_rdM, 32'hFFFF_FF80);
    chk("lb_addr", dm_addr, 32'h100);
    chk("lb_be", {28'b0, dm_be}, 32'h8);
    chk("lb_we", {31'b0, dm_we}, 32'd0);
    idleIn();
    tick();

    // LBU 0x103
    doAccess(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_FFFF, 0, 0,
             stalls, reqs, done);
    chk("lbu_rdM", dm_rdM, 32'h0000_0080);
    idleIn();
    tick();

    // LH 0x102 with rvalid 3 cycles after grant
    doAccess(1'b0, 3'b001, 32'h102, 32'h0, 32'h8001_0000, 0, 2,
             stalls, reqs, done);
    chk("lh_stall", stalls, 32'd5);
    chk("lh_rdM", dm_rdM, 32'hFFFF_8001);
    chk("lh_be", {28'b0, dm_be}, 32'hC);
    idleIn();
    tick();

    doAccess(1'b0, 3'b101, 32'h102, 32'h0, 32'h8001_0000, 0, 0,
             stalls, reqs, done);
    chk("lhu_rdM", dm_rdM, 32'h0000_8001);
    idleIn();
    tick();

    // Reset while waiting for rvalid
    validM   = 1'b1;
    memreadM = 1'b1;
    funct3M  = 3'b010;
    addrM    = 32'h200;
    dm_rdata = 32'h1234_5678;
    tick();
    chk("rw_req", {31'b0, dm_req}, 32'd1);
    dm_gnt = 1'b1;
    tick();
    dm_gnt = 1'b0;
    chk("rw_wait_stall", {31'b0, stallM}, 32'd1);
    idleIn();
    rst_n = 1'b0;
    #1;
    chk("rw_rst_rdM", dm_rdM, 32'd0);
    chk("rw_rst_stall", {31'b0, stallM}, 32'd0);
    #2;
    rst_n = 1'b1;
    dm_rvalid = 1'b1;
    tick();
    dm_rvalid = 1'b0;
    chk("rw_late_rdM", dm_rdM, 32'd0);
    chk("rw_late_req", {31'b0, dm_req}, 32'd0);
    chk("rw_late_stall", {31'b0, stallM}, 32'd0);
    tick();

    // SH 0x202, grant delayed 3 cycles
    doAccess(1'b0, 3'b001, 32'h202, 32'h0, 32'h0001_0000, 0, 0,
             stalls, reqs, done);
    chk("pre_sh_rdM", dm_rdM, 32'h0000_0001);
    idleIn();
    tick();
    doAccess(1'b1, 3'b001, 32'h202, 32'h0000_1234, 32'h0, 3, 0,
             stalls, reqs, done);
    chk("sh_done", {31'b0, done}, 32'd1);
    chk("sh_reqs", reqs, 32'd4);
    chk("sh_stall", stalls, 32'd5);
    chk("sh_be", {28'b0, dm_be}, 32'hC);
    chk("sh_wdata", dm_wdata, 32'h1234_1234);
    chk("sh_addr", dm_addr, 32'h200);
    chk("sh_rdM", dm_rdM, 32'd0);

    // holdM in DONE: instruction stays retired, no new request
    holdM = 1'b1;
    tick();
    chk("hold1_stall", {31'b0, stallM}, 32'd0);
    chk("hold1_req", {31'b0, dm_req}, 32'd0);
    tick();
    chk("hold2_stall", {31'b0, stallM}, 32'd0);
    chk("hold2_req", {31'b0, dm_req}, 32'd0);
    holdM = 1'b0;
    idleIn();
    tick();
    chk("hold_exit_req", {31'b0, dm_req}, 32'd0);

    // LW 0x300 to leave nonzero load data
    doAccess(1'b0, 3'b010, 32'h300, 32'h0, 32'h1122_3344, 1, 0,
             stalls, reqs, done);
    chk("lw_stall", stalls, 32'd4);
    chk("lw_rdM", dm_rdM, 32'h1122_3344);
    idleIn();
    tick();

    // LW 0x101
`ifdef LSU_MISALIGN_TRAP_EN
    validM   = 1'b1;
    memreadM = 1'b1;
    funct3M  = 3'b010;
    addrM    = 32'h101;
    #1;
    chk("mis_stall", {31'b0, stallM}, 32'd1);
    tick();
    chk("mis_req", {31'b0, dm_req}, 32'd0);
    chk("mis_flag", {31'b0, misalignM}, 32'd1);
    chk("mis_done_stall", {31'b0, stallM}, 32'd0);
    chk("mis_rdM", dm_rdM, 32'd0);
    idleIn();
    tick();
    chk("mis_clear", {31'b0, misalignM}, 32'd0);
    chk("mis_idle_req", {31'b0, dm_req}, 32'd0);
`else
    doAccess(1'b0, 3'b010, 32'h101, 32'h0, 32'hCAFE_F00D, 0, 0,
             stalls, reqs, done);
    chk("lwu_done", {31'b0, done}, 32'd1);
    chk("lwu_stall", stalls, 32'd3);
    chk("lwu_addr", dm_addr, 32'h100);
    chk("lwu_be", {28'b0, dm_be}, 32'hF);
    chk("lwu_rdM", dm_rdM, 32'hCAFE_F00D);
    chk("lwu_mis", {31'b0, misalignM}, 32'd0);
    idleIn();
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
